parking_gate_ctrl: RTL and testbench
====================================

# parking_gate_ctrl

Parametrised parking-gate controller, the next generation of the single-entry PIN gate FSM. Adds configurable PIN width and value, configurable attempt limit, a PIN-entry timeout, a lot-occupancy counter with full-lot rejection, and an operator unlock that clears both alarm lockouts. Sits between the entry kiosk (arrival sensor, keypad) and the gate actuator, with an exit sensor feeding the occupancy count.

## Interface
- CODE_W, 16: PIN width in bits.
- CORRECT_CODE, 16'h5990: accepted PIN.
- MAX_ATTEMPTS, 3: wrong PINs that trigger lockout; legal range 1..15.
- PIN_TIMEOUT, 1000: cycles allowed in WAIT_PIN without code_ack; legal range ≥2.
- CAPACITY, 32: lot spaces; legal range ≥1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vehicle_arrival  in  1  level, vehicle at entry sensor.
- vehicle_left  in  1  level, vehicle cleared entry gate.
- code  in  CODE_W  keypad PIN, valid while code_ack high.
- code_ack  in  1  level, PIN submitted.
- gate_ack  in  1  actuator reports gate closed.
- vehicle_exit  in  1  single-cycle pulse, a vehicle left the lot by the exit.
- unlock  in  1  operator clear of a lockout.
- open_gate  out  1  drive gate open.
- close_gate  out  1  drive gate closed.
- wrong_pin  out  1  alarm, attempt limit reached.
- blocked_gate  out  1  alarm, tailgating detected.
- lot_full  out  1  occupancy == CAPACITY.
- occupancy  out  $clog2(CAPACITY+1)  vehicles in lot.

## Operation
- States: IDLE, WAIT_PIN, BAD_PIN, OPEN, CLOSING, LOCK_PIN, LOCK_TAIL. Unused encodings go to IDLE next cycle, attempts cleared, all gate/alarm outputs 0.
- Outputs decoded from the state register (Moore): open_gate in OPEN; close_gate in CLOSING; wrong_pin in LOCK_PIN; blocked_gate in LOCK_TAIL. lot_full, occupancy from the occupancy register.
- IDLE: vehicle_arrival && !lot_full → WAIT_PIN. Arrival while lot_full is ignored.
- WAIT_PIN, priority order: vehicle_left → IDLE, attempts := 0; else code_ack → OPEN if code == CORRECT_CODE, else BAD_PIN; else timer == PIN_TIMEOUT-1 → IDLE, attempts := 0; else timer+1.
- Timer cleared on every entry to WAIT_PIN.
- BAD_PIN: hold while code_ack high. On code_ack low: if attempts+1 == MAX_ATTEMPTS → LOCK_PIN, else attempts+1 and → WAIT_PIN.
- OPEN: attempts := 0. vehicle_left && vehicle_arrival → LOCK_TAIL; vehicle_left alone → CLOSING. Both transitions increment occupancy by 1 (authorised vehicle entered).
- CLOSING: gate_ack → IDLE.
- LOCK_PIN / LOCK_TAIL: held until unlock; unlock → CLOSING, attempts := 0. All other inputs ignored.
- Occupancy: +1 on entry event, −1 on vehicle_exit when occupancy > 0 (saturate at 0). Entry and exit in the same cycle: unchanged. Never exceeds CAPACITY (entry only admitted when not full).
- Attempts counter width $clog2(MAX_ATTEMPTS+1); never exceeds MAX_ATTEMPTS-1.

## Timing
- rst sampled on clk edge: state IDLE, attempts 0, timer 0, occupancy 0; all outputs 0 from the following cycle (lot_full 0).
- rst mid-operation (any state, including lockouts) returns to IDLE in one cycle, occupancy lost.
- Input-to-output latency one cycle: an input sampled at edge N changes state at N; outputs valid after edge N.
- Timeout: entering WAIT_PIN at edge E with no code_ack/vehicle_left, state is IDLE after edge E+PIN_TIMEOUT.
- code_ack sampled once per submission; BAD_PIN requires code_ack low for one sampled edge before the next PIN is accepted.
- lot_full updates the cycle after the occupancy change; an arrival sampled in that same edge sees the old value.

## Test plan
- Correct PIN: arrival, code=16'h5990 with code_ack → open_gate 1 cycle after; vehicle_left → close_gate, occupancy 0→1; gate_ack → IDLE.
- Lockout: 3 wrong PINs (16'h0000), each with code_ack pulse → after the 3rd release wrong_pin=1; code ignored; unlock → close_gate, gate_ack → IDLE, attempts 0.
- Tailgate: in OPEN drive vehicle_left=1 and vehicle_arrival=1 together → blocked_gate=1, occupancy+1; unlock clears.
- Timeout with PIN_TIMEOUT=10: arrival, no code_ack → IDLE exactly 10 cycles after entering WAIT_PIN; code_ack on cycle 10 wins over timeout.
- Full lot with CAPACITY=2: two admissions → lot_full=1, third arrival stays IDLE; vehicle_exit pulse → occupancy 1, lot_full 0; vehicle_exit at occupancy 0 leaves 0; entry+exit same cycle leaves occupancy unchanged.
- Reset mid-lock: in LOCK_PIN assert rst one cycle → all outputs 0, occupancy 0, IDLE.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// Parking-gate controller: PIN-gated single entry with attempt lockout, PIN timeout,
// tailgate detection and a saturating lot-occupancy counter with full-lot rejection.
module parking_gate_ctrl #(
    parameter int unsigned          CODE_W       = 16,
    parameter logic [CODE_W-1:0]    CORRECT_CODE = CODE_W'(16'h5990),
    parameter int unsigned          MAX_ATTEMPTS = 3,
    parameter int unsigned          PIN_TIMEOUT  = 1000,
    parameter int unsigned          CAPACITY     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vehicle_arrival,
    input  logic                            vehicle_left,
    input  logic [CODE_W-1:0]               code,
    input  logic                            code_ack,
    input  logic                            gate_ack,
    input  logic                            vehicle_exit,
    input  logic                            unlock,
    output logic                            open_gate,
    output logic                            close_gate,
    output logic                            wrong_pin,
    output logic                            blocked_gate,
    output logic                            lot_full,
    output logic [$clog2(CAPACITY+1)-1:0]   occupancy
);

    localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned TMR_W = $clog2(PIN_TIMEOUT);
    localparam int unsigned OCC_W = $clog2(CAPACITY + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PIN  = 3'd1,
        BAD_PIN   = 3'd2,
        OPEN      = 3'd3,
        CLOSING   = 3'd4,
        LOCK_PIN  = 3'd5,
        LOCK_TAIL = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               lot_full_q;
    logic               open_q, close_q, wrong_q, blocked_q;
    logic               entry;

    // Next-state, attempt counter and PIN timer
    always_comb begin
        state_d = state_q;
        att_d   = att_q;
        tmr_d   = '0;
        entry   = 1'b0;
        case (state_q)
            IDLE: begin
                if (vehicle_arrival && !lot_full_q) state_d = WAIT_PIN;
            end
            WAIT_PIN: begin
                if (vehicle_left) begin
                    state_d = IDLE;
                    att_d   = '0;
                end else if (code_ack) begin
                    state_d = (code == CORRECT_CODE) ? OPEN : BAD_PIN;
                end else if (tmr_q == TMR_W'(PIN_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    att_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            BAD_PIN: begin
                // Wait for keypad release so one held submission counts once
                if (!code_ack) begin
                    if (att_q + ATT_W'(1) == ATT_W'(MAX_ATTEMPTS)) begin
                        state_d = LOCK_PIN;
                    end else begin
                        att_d   = att_q + ATT_W'(1);
                        state_d = WAIT_PIN;
                    end
                end
            end
            OPEN: begin
                att_d = '0;
                if (vehicle_left) begin
                    entry   = 1'b1;
                    state_d = vehicle_arrival ? LOCK_TAIL : CLOSING;
                end
            end
            CLOSING: begin
                if (gate_ack) state_d = IDLE;
            end
            LOCK_PIN, LOCK_TAIL: begin
                if (unlock) begin
                    state_d = CLOSING;
                    att_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                att_d   = '0;
            end
        endcase
    end

    // Occupancy: simultaneous entry and exit cancel out
    always_comb begin
        occ_d = occ_q;
        if (entry && !vehicle_exit) begin
            if (occ_q < OCC_W'(CAPACITY)) occ_d = occ_q + OCC_W'(1);
        end else if (!entry && vehicle_exit && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            att_q      <= '0;
            tmr_q      <= '0;
            occ_q      <= '0;
            lot_full_q <= 1'b0;
            open_q     <= 1'b0;
            close_q    <= 1'b0;
            wrong_q    <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            att_q      <= att_d;
            tmr_q      <= tmr_d;
            occ_q      <= occ_d;
            lot_full_q <= (occ_d == OCC_W'(CAPACITY));
            open_q     <= (state_d == OPEN);
            close_q    <= (state_d == CLOSING);
            wrong_q    <= (state_d == LOCK_PIN);
            blocked_q  <= (state_d == LOCK_TAIL);
        end
    end

    assign open_gate    = open_q;
    assign close_gate   = close_q;
    assign wrong_pin    = wrong_q;
    assign blocked_gate = blocked_q;
    assign lot_full     = lot_full_q;
    assign occupancy    = occ_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with a short PIN timeout and a two-space lot.
module tb_parking_gate_ctrl;

    localparam int unsigned CODE_W = 16;
    localparam int unsigned CAP    = 2;
    localparam int unsigned OCC_W  = $clog2(CAP + 1);
    localparam logic [CODE_W-1:0] CODE_OK  = 16'h5990;
    localparam logic [CODE_W-1:0] CODE_BAD = 16'h0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              vehicle_arrival, vehicle_left, code_ack, gate_ack, vehicle_exit, unlock;
    logic [CODE_W-1:0] code;
    logic              open_gate, close_gate, wrong_pin, blocked_gate, lot_full;
    logic [OCC_W-1:0]  occupancy;

    int n_chk = 0;
    int n_err = 0;

    parking_gate_ctrl #(
        .CODE_W       (CODE_W),
        .CORRECT_CODE (CODE_OK),
        .MAX_ATTEMPTS (3),
        .PIN_TIMEOUT  (10),
        .CAPACITY     (CAP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vehicle_arrival (vehicle_arrival),
        .vehicle_left    (vehicle_left),
        .code            (code),
        .code_ack        (code_ack),
        .gate_ack        (gate_ack),
        .vehicle_exit    (vehicle_exit),
        .unlock          (unlock),
        .open_gate       (open_gate),
        .close_gate      (close_gate),
        .wrong_pin       (wrong_pin),
        .blocked_gate    (blocked_gate),
        .lot_full        (lot_full),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [CODE_W-1:0] c);
        code     = c;
        code_ack = 1'b1;
        step(1);
        code_ack = 1'b0;
    endtask

    task automatic arrive();
        vehicle_arrival = 1'b1;
        step(1);
        vehicle_arrival = 1'b0;
    endtask

    task automatic close_out();
        gate_ack = 1'b1;
        step(1);
        gate_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        vehicle_arrival = 0; vehicle_left = 0; code_ack = 0;
        gate_ack = 0; vehicle_exit = 0; unlock = 0; code = '0;
        step(2);
        rst = 1'b0;
        check("rst_open",     32'(open_gate),    0);
        check("rst_close",    32'(close_gate),   0);
        check("rst_wrong",    32'(wrong_pin),    0);
        check("rst_blocked",  32'(blocked_gate), 0);
        check("rst_full",     32'(lot_full),     0);
        check("rst_occ",      32'(occupancy),    0);

        // Correct PIN admission
        arrive();
        check("wait_no_open", 32'(open_gate), 0);
        press(CODE_OK);
        check("ok_open", 32'(open_gate), 1);
        vehicle_left = 1'b1; step(1); vehicle_left = 1'b0;
        check("ok_close",     32'(close_gate), 1);
        check("ok_open_off",  32'(open_gate),  0);
        check("ok_occ",       32'(occupancy),  1);
        close_out();
        check("ok_idle", 32'(close_gate), 0);

        // Three wrong PINs lock out; locked state ignores the keypad
        arrive();
        for (int i = 0; i < 3; i++) begin
            press(CODE_BAD);
            check("bad_hold", 32'(wrong_pin), 0);
            step(1);
            check("bad_release", 32'(wrong_pin), (i == 2) ? 32'd1 : 32'd0);
        end
        press(CODE_OK);
        check("lock_ignore_wrong", 32'(wrong_pin), 1);
        check("lock_ignore_open",  32'(open_gate), 0);
        unlock = 1'b1; step(1); unlock = 1'b0;
        check("unlock_close", 32'(close_gate), 1);
        check("unlock_wrong", 32'(wrong_pin),  0);
        close_out();
        arrive();
        press(CODE_BAD); step(1);
        check("att_cleared", 32'(wrong_pin), 0);
        vehicle_left = 1'b1; step(1); vehicle_left = 1'b0;
        check("left_wait_occ",   32'(occupancy),  1);
        check("left_wait_close", 32'(close_gate), 0);

        // Tailgate fills the lot
        arrive();
        press(CODE_OK);
        check("tg_open", 32'(open_gate), 1);
        vehicle_left = 1'b1; vehicle_arrival = 1'b1; step(1);
        vehicle_left = 1'b0; vehicle_arrival = 1'b0;
        check("tg_blocked", 32'(blocked_gate), 1);
        check("tg_occ",     32'(occupancy),    2);
        check("tg_full",    32'(lot_full),     1);
        unlock = 1'b1; step(1); unlock = 1'b0;
        check("tg_unlock_close",   32'(close_gate),   1);
        check("tg_unlock_blocked", 32'(blocked_gate), 0);
        close_out();

        // Arrival at a full lot is ignored
        vehicle_arrival = 1'b1; step(1);
        press(CODE_OK);
        vehicle_arrival = 1'b0;
        check("full_reject", 32'(open_gate), 0);
        vehicle_exit = 1'b1; step(1); vehicle_exit = 1'b0;
        check("exit_occ1",  32'(occupancy), 1);
        check("exit_full0", 32'(lot_full),  0);
        vehicle_exit = 1'b1; step(1);
        check("exit_occ0", 32'(occupancy), 0);
        step(1); vehicle_exit = 1'b0;
        check("exit_sat0", 32'(occupancy), 0);

        // PIN accepted on the last timer cycle
        arrive();
        step(9);
        press(CODE_OK);
        check("ack_beats_timeout", 32'(open_gate), 1);
        vehicle_left = 1'b1; step(1); vehicle_left = 1'b0;
        check("to_occ", 32'(occupancy), 1);
        close_out();

        // Timeout returns to IDLE exactly PIN_TIMEOUT edges after entry
        arrive();
        step(10);
        press(CODE_OK);
        check("timeout_idle", 32'(open_gate), 0);

        // Entry and exit in the same cycle cancel
        arrive();
        press(CODE_OK);
        vehicle_left = 1'b1; vehicle_exit = 1'b1; step(1);
        vehicle_left = 1'b0; vehicle_exit = 1'b0;
        check("same_cycle_occ",   32'(occupancy),  1);
        check("same_cycle_close", 32'(close_gate), 1);
        close_out();

        // Reset while locked
        arrive();
        for (int i = 0; i < 3; i++) begin
            press(CODE_BAD);
            step(1);
        end
        check("pre_rst_lock", 32'(wrong_pin), 1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("mrst_wrong", 32'(wrong_pin),  0);
        check("mrst_close", 32'(close_gate), 0);
        check("mrst_open",  32'(open_gate),  0);
        check("mrst_occ",   32'(occupancy),  0);
        check("mrst_full",  32'(lot_full),   0);
        arrive();
        press(CODE_OK);
        check("post_rst_open", 32'(open_gate), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
